test_i8736: RTL and testbench



---
 rtl/test_i8736.sv | 57 +++++
 tb/tb_test_i8736.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/test_i8736.sv
// test_i8736: Mealy detector for a programmable 3-symbol sequence on the
// 2-bit stream {N0,N1}. The two most recent sampled symbols are kept in a
// plain shift history with per-stage valid bits. The final symbol is matched
// combinationally against the live inputs, so the flag rises in the same
// cycle the last symbol is presented.
module test_i8736 #(
   parameter logic [1:0] SEQ0 = 2'b01,
   parameter logic [1:0] SEQ1 = 2'b10,
   parameter logic [1:0] SEQ2 = 2'b11
) (
   input  logic CK,
   input  logic reset,
   input  logic N0,
   input  logic N1,
   output logic output_single
);

   // Number of sampled symbols held in the history (SEQ0 and SEQ1).
   localparam int DEPTH = 2;

   // Expected history, indexed by age: [0] = last edge (SEQ1),
   // [1] = edge before (SEQ0).
   localparam logic [DEPTH-1:0][1:0] EXP_HIST = {SEQ0, SEQ1};

   logic [1:0]            sym;
   // Power-up value equals the reset value, so the block behaves even if
   // reset is never asserted before the first edge.
   logic [DEPTH-1:0][1:0] hist_reg  = '0;
   logic [DEPTH-1:0]      valid_reg = '0;
   logic [DEPTH-1:0]      stage_match;

   assign sym = {N0, N1};

   // Shift the live symbol into the history; reset discards everything,
   // including any partially matched sequence.
   always_ff @(posedge CK) begin
      if (reset) begin
         hist_reg  <= '0;
         valid_reg <= '0;
      end else begin
         hist_reg  <= {hist_reg[DEPTH-2:0], sym};
         valid_reg <= {valid_reg[DEPTH-2:0], 1'b1};
      end
   end

   // Each history stage matches only once it holds a real sample, so the
   // 00 reset contents never fake a match when SEQ0 or SEQ1 is 2'b00.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         assign stage_match[gi] = valid_reg[gi] & (hist_reg[gi] == EXP_HIST[gi]);
      end
   endgenerate

   // Mealy output: history plus live symbol, forced low while in reset.
   assign output_single = ~reset & (&stage_match) & (sym == SEQ2);

endmodule

// File: tb/tb_test_i8736.sv
// Bench for test_i8736. Three instances share one stimulus stream:
//   a: default sequence 01 -> 10 -> 11
//   b: 11 -> 11 -> 11 (overlapping / sustained runs)
//   c: 00 -> 00 -> 01 (history of 00 must not match before it is valid)
// The reference model keeps the list of symbols sampled since the last
// reset and evaluates the detection rule directly from it.
module tb_test_i8736;

   logic CK = 1'b0;
   logic reset;
   logic N0;
   logic N1;
   logic out_a;
   logic out_b;
   logic out_c;

   int   n_checks = 0;
   int   n_errors = 0;
   bit   running  = 1'b0;

   // Symbols sampled on clean edges since the most recent reset edge.
   logic [1:0] hist_q[$];

   test_i8736 dut_a (
      .CK(CK), .reset(reset), .N0(N0), .N1(N1), .output_single(out_a)
   );

   test_i8736 #(.SEQ0(2'b11), .SEQ1(2'b11), .SEQ2(2'b11)) dut_b (
      .CK(CK), .reset(reset), .N0(N0), .N1(N1), .output_single(out_b)
   );

   test_i8736 #(.SEQ0(2'b00), .SEQ1(2'b00), .SEQ2(2'b01)) dut_c (
      .CK(CK), .reset(reset), .N0(N0), .N1(N1), .output_single(out_c)
   );

   always #5 CK = ~CK;

   // Detection rule: not in reset, at least two samples since reset, the
   // two most recent samples equal SEQ0 then SEQ1, live symbol equals SEQ2.
   function automatic logic model(input logic [1:0] s0, input logic [1:0] s1,
                                  input logic [1:0] s2);
      int n;
      n = hist_q.size();
      if (reset) return 1'b0;
      if (n < 2) return 1'b0;
      return (hist_q[n-2] == s0) && (hist_q[n-1] == s1) && ({N0, N1} == s2);
   endfunction

   // Model history update on every rising edge.
   always @(posedge CK) begin
      if (reset) begin
         hist_q.delete();
      end else begin
         hist_q.push_back({N0, N1});
         if (hist_q.size() > 2) void'(hist_q.pop_front());
      end
   end

   task automatic check(input string name, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
      end
   endtask

   // Continuous compare against the model, mid-cycle.
   always @(negedge CK) begin
      if (running) begin
         check("model_a", out_a, model(2'b01, 2'b10, 2'b11));
         check("model_b", out_b, model(2'b11, 2'b11, 2'b11));
         check("model_c", out_c, model(2'b00, 2'b00, 2'b01));
      end
   end

   // Apply one vector, then check literal expectations (-1 = don't care)
   // against both the DUT and the model, then advance one edge.
   task automatic drive(input logic r, input logic [1:0] s,
                        input int ea, input int eb, input int ec);
      reset = r;
      {N0, N1} = s;
      #2;
      if (ea >= 0) begin
         check("lit_a", out_a, ea[0]);
         check("lit_model_a", model(2'b01, 2'b10, 2'b11), ea[0]);
      end
      if (eb >= 0) begin
         check("lit_b", out_b, eb[0]);
         check("lit_model_b", model(2'b11, 2'b11, 2'b11), eb[0]);
      end
      if (ec >= 0) begin
         check("lit_c", out_c, ec[0]);
         check("lit_model_c", model(2'b00, 2'b00, 2'b01), ec[0]);
      end
      $display("t=%0t reset=%b sym=%b%b out a=%b b=%b c=%b", $time, reset, N0, N1,
               out_a, out_b, out_c);
      @(posedge CK);
      #1;
   endtask

   initial begin
      running = 1'b1;

      // Power-up without reset: initial state behaves like reset state.
      drive(1'b0, 2'b01, 0, 0, 0);
      drive(1'b0, 2'b10, 0, 0, -1);
      drive(1'b0, 2'b11, 1, 0, -1);

      // Reset, then 11 with invalid history.
      drive(1'b1, 2'b11, 0, 0, 0);
      drive(1'b0, 2'b11, 0, 0, -1);

      // Clean detect, then drop after the next edge.
      drive(1'b0, 2'b01, 0, 0, -1);
      drive(1'b0, 2'b10, 0, 0, -1);
      drive(1'b0, 2'b11, 1, 0, -1);
      drive(1'b0, 2'b00, 0, 0, -1);

      // Broken sequence: 01, 00, 10 then 11.
      drive(1'b0, 2'b01, 0, 0, -1);
      drive(1'b0, 2'b00, 0, 0, -1);
      drive(1'b0, 2'b10, 0, 0, -1);
      drive(1'b0, 2'b11, 0, 0, -1);

      // Reset mid-sequence clears history.
      drive(1'b0, 2'b01, 0, 0, -1);
      drive(1'b0, 2'b10, 0, 0, -1);
      drive(1'b1, 2'b11, 0, 0, 0);
      drive(1'b0, 2'b00, 0, 0, -1);
      drive(1'b0, 2'b00, 0, 0, -1);
      drive(1'b0, 2'b11, 0, 0, -1);

      // Sustained run of 11 on the all-11 instance.
      drive(1'b1, 2'b11, 0, 0, 0);
      drive(1'b0, 2'b11, 0, 0, -1);
      drive(1'b0, 2'b11, 0, 0, -1);
      drive(1'b0, 2'b11, 0, 1, -1);
      drive(1'b0, 2'b11, 0, 1, -1);
      drive(1'b0, 2'b11, 0, 1, -1);
      drive(1'b1, 2'b11, 0, 0, 0);

      // 00-valued sequence: reset contents must not count as history.
      drive(1'b1, 2'b00, 0, 0, 0);
      drive(1'b0, 2'b01, 0, 0, 0);
      drive(1'b0, 2'b00, 0, 0, 0);
      drive(1'b0, 2'b00, 0, 0, 0);
      drive(1'b0, 2'b01, 0, 0, 1);
      drive(1'b0, 2'b10, 0, 0, 0);

      running = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
